// File: rtl/particle_record_fifo.sv
// Elastic first-word-fall-through buffer for particle records ahead of the compute stage.
// Optional PARTICLE_RECORD_FIFO_STATS_EN adds a high-water mark and an upstream stall counter.
module particle_record_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PARTICLE_RECORD_FIFO_STATS_EN
  output logic [CNT_W-1:0] max_count,
  output logic [15:0]      stall_cycles,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // The extra pointer MSB separates full from empty when low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  // Storage is never cleared; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

`ifdef PARTICLE_RECORD_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (count_next > max_count) max_count <= count_next;
      if (in_valid && !in_ready && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_particle_record_fifo.sv
// Randomized self-checking bench for particle_record_fifo against a queue model.
// Stats checks are compiled in when PARTICLE_RECORD_FIFO_STATS_EN is defined.
module tb_particle_record_fifo;

  localparam int W = 105;
  localparam int D = 16;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
`ifdef PARTICLE_RECORD_FIFO_STATS_EN
  logic [CW-1:0] max_count;
  logic [15:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mq[$];

  always #5 clk = ~clk;

  particle_record_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef PARTICLE_RECORD_FIFO_STATS_EN
    .max_count(max_count),
    .stall_cycles(stall_cycles),
`endif
    .count(count)
  );

  // Advance one clock edge and apply the handshake rules to the model.
  task automatic step();
    logic pu;
    logic po;
    pu = in_valid && (mq.size() < D);
    po = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (po) mq.delete(0);
    if (pu) mq.push_back(in_data);
    #1;
  endtask

  function automatic logic [W-1:0] rand_rec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL reset: out_valid=%b in_ready=%b count=%0d want 0 1 0",
               out_valid, in_ready, count);
    end
  endtask

  task automatic test_single();
    in_data = 105'h1_2345_6789_ABCD;
    in_valid = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_bypass: out_valid=%b want 0", out_valid);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 105'h1_2345_6789_ABCD || count !== 1) begin
      errors++;
      $display("FAIL single_push: v=%b data=%h count=%0d want 1 %h 1",
               out_valid, out_data, count, 105'h1_2345_6789_ABCD);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 0) begin
      errors++;
      $display("FAIL single_pop: v=%b count=%0d want 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      in_data = W'(i);
      step();
    end
    checks++;
    if (count !== D || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill: count=%0d in_ready=%b want 16 0", count, in_ready);
    end
    in_data = W'(99);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (count !== D || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_hold: count=%0d in_ready=%b want 16 0", count, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        errors++;
        $display("FAIL drain_order: v=%b data=%0h want 1 %0h", out_valid, out_data, i);
      end
      step();
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1 || count !== D - 1) begin
          errors++;
          $display("FAIL first_pop: in_ready=%b count=%0d want 1 15", in_ready, count);
        end
      end
    end
    checks++;
    if (count !== 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained: count=%0d v=%b want 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      in_data = rand_rec();
      step();
    end
    in_data = rand_rec();
    out_ready = 1'b1;
    step();
    checks++;
    if (count !== D - 1 || in_ready !== 1'b1 || int'(count) != mq.size()) begin
      errors++;
      $display("FAIL full_pop: count=%0d in_ready=%b want %0d 1", count, in_ready, mq.size());
    end
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== D || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_refill: count=%0d in_ready=%b want 16 0", count, in_ready);
    end
    out_ready = 1'b1;
    while (mq.size() != 0) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== mq[0]) begin
        errors++;
        $display("FAIL full_drain: data=%h want %h", out_data, mq[0]);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(1000 + i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = W'(1004 + i);
      if (out_data !== W'(1000 + i) || out_data !== mq[0] || count !== 4) bad++;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL back_to_back: %0d bad cycles want 0", bad);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== W'(1100 + i)) begin
        errors++;
        $display("FAIL b2b_tail: data=%0h want %0h", out_data, 1100 + i);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = rand_rec();
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 9) begin
      errors++;
      $display("FAIL pre_rst: count=%0d want 9", count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: v=%b count=%0d rdy=%b want 0 0 1", out_valid, count, in_ready);
    end
    mq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    in_data = W'(7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(7) || count !== 1) begin
      errors++;
      $display("FAIL post_rst: v=%b data=%h count=%0d want 1 7 1", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = rand_rec();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (i > 100 && i < 160) out_ready = 1'b0;
      if (out_valid !== (mq.size() != 0) || int'(count) != mq.size() ||
          in_ready !== (mq.size() < D) ||
          (mq.size() != 0 && out_data !== mq[0])) begin
        bad++;
        if (bad < 5)
          $display("FAIL random: cyc %0d count=%0d want %0d v=%b rdy=%b",
                   i, count, mq.size(), out_valid, in_ready);
      end
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_total: %0d bad cycles want 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (mq.size() != 0) step();
    out_ready = 1'b0;
  endtask

`ifdef PARTICLE_RECORD_FIFO_STATS_EN
  task automatic test_stats();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = rand_rec();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (mq.size() != 0) step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = rand_rec();
      step();
    end
    checks++;
    if (max_count !== 12 || stall_cycles !== 0) begin
      errors++;
      $display("FAIL max_count: got %0d stall %0d want 12 0", max_count, stall_cycles);
    end
    for (int i = 0; i < 11; i++) begin
      in_data = rand_rec();
      step();
    end
    for (int i = 0; i < 20; i++) step();
    in_valid = 1'b0;
    checks++;
    if (stall_cycles !== 20 || max_count !== D) begin
      errors++;
      $display("FAIL stall_cycles: got %0d max %0d want 20 16", stall_cycles, max_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pop_push();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef PARTICLE_RECORD_FIFO_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
